// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider (ratio 2..15) with hitless ratio changes at period boundaries.
// Build option CLKDIV_ODD_DUTY_EN adds a falling-edge flop for exact 50% duty on odd ratios.
module clkdiv_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_div,
    output logic       cfg_ready,
    output logic       cfg_err,
    output logic [3:0] cur_div,
    output logic       div_out,
    output logic       tick,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StRun, StPend, StStop} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cur_div_q, cur_div_d;
    logic [3:0] pend_q, pend_d;
    logic       loaded_q, loaded_d;
    logic       div_q, div_d;
    logic       tick_q, tick_d;
    logic       err_q, err_d;

    logic       xfer;
    logic       legal;
    logic       wrap;
    logic       busy_d;
    logic [4:0] high_len;

    // Gated by reset so no transfer is advertised while the block is held.
    assign cfg_ready = ~reset & ((state_q == StIdle) | (state_q == StRun));
    assign xfer      = cfg_valid & cfg_ready;
    assign legal     = (cfg_div >= 4'd2);
    assign wrap      = (cnt_q == (cur_div_q - 4'd1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        loaded_d  = loaded_q;
        err_d     = xfer & ~legal;

        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (xfer && legal) begin
                    cur_div_d = cfg_div;
                    loaded_d  = 1'b1;
                end
                if (en && (loaded_q || (xfer && legal))) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
                if (xfer && legal && wrap) begin
                    cur_div_d = cfg_div;
                    if (!en) begin
                        state_d = StIdle;
                    end
                end else if (xfer && legal) begin
                    pend_d  = cfg_div;
                    state_d = StPend;
                end else if (!en) begin
                    state_d = wrap ? StIdle : StStop;
                end
            end
            StPend: begin
                cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
                if (wrap) begin
                    cur_div_d = pend_q;
                    pend_d    = 4'd0;
                    state_d   = en ? StRun : StIdle;
                end
            end
            StStop: begin
                cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
                if (en) begin
                    state_d = StRun;
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are registered from next-state values so they align with cnt.
        busy_d   = (state_d != StIdle);
        high_len = ({1'b0, cur_div_d} + 5'd1) >> 1;
        div_d    = busy_d & ({1'b0, cnt_d} < high_len);
        tick_d   = busy_d & (cnt_d == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            cur_div_q <= 4'd0;
            pend_q    <= 4'd0;
            loaded_q  <= 1'b0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            loaded_q  <= loaded_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign tick    = tick_q;
    assign cfg_err = err_q;
    assign cur_div = cur_div_q;

`ifdef CLKDIV_ODD_DUTY_EN
    logic div_fall_q;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            div_fall_q <= 1'b0;
        end else begin
            div_fall_q <= div_q;
        end
    end

    // Odd ratios: trimming the high phase by half a cycle gives N/2 high, N/2 low.
    assign div_out = cur_div_q[0] ? (div_q & div_fall_q) : div_q;
`else
    assign div_out = div_q;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: period-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_clkdiv_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       cfg_valid;
    logic [3:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic [3:0] cur_div;
    logic       div_out;
    logic       tick;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    clkdiv_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cur_div   (cur_div),
        .div_out   (div_out),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a running divider is a position within a period of a given ratio.
    // Ratio changes and stop requests only take effect where one period ends.
    int   m_pos;
    int   m_ratio;
    int   m_pend;
    logic m_active;
    logic m_has_pend;
    logic m_stopping;
    logic m_loaded;
    logic m_err;

    function automatic logic model_ready();
        return !m_active || (!m_has_pend && !m_stopping);
    endfunction

    always @(posedge clk or posedge reset) begin : model
        logic rdy, xfer, legal, last;
        if (reset) begin
            m_pos      <= 0;
            m_ratio    <= 0;
            m_pend     <= 0;
            m_active   <= 1'b0;
            m_has_pend <= 1'b0;
            m_stopping <= 1'b0;
            m_loaded   <= 1'b0;
            m_err      <= 1'b0;
        end else begin
            rdy   = model_ready();
            xfer  = cfg_valid && rdy;
            legal = (cfg_div >= 4'd2);
            m_err <= xfer && !legal;
            if (!m_active) begin
                if (xfer && legal) begin
                    m_ratio  <= int'(cfg_div);
                    m_loaded <= 1'b1;
                end
                if (en && (m_loaded || (xfer && legal))) m_active <= 1'b1;
                m_pos      <= 0;
                m_stopping <= 1'b0;
            end else begin
                last = (m_pos == m_ratio - 1);
                if (last) begin
                    m_pos <= 0;
                    if (xfer && legal) m_ratio <= int'(cfg_div);
                    else if (m_has_pend) m_ratio <= m_pend;
                    m_has_pend <= 1'b0;
                    m_active   <= en;
                    m_stopping <= 1'b0;
                end else begin
                    m_pos <= m_pos + 1;
                    if (xfer && legal) begin
                        m_has_pend <= 1'b1;
                        m_pend     <= int'(cfg_div);
                    end
                    m_stopping <= !en;
                end
            end
        end
    end

    // Every-cycle comparison just after the active edge.
    always @(posedge clk) begin : compare
        logic exp_div;
        #1;
`ifdef CLKDIV_ODD_DUTY_EN
        if (m_ratio % 2 == 1) exp_div = m_active && (m_pos >= 1) && (m_pos < (m_ratio + 1) / 2);
        else exp_div = m_active && (m_pos < m_ratio / 2);
`else
        exp_div = m_active && (m_pos < (m_ratio + 1) / 2);
`endif
        check("model_busy", 16'(busy), 16'(m_active));
        check("model_tick", 16'(tick), 16'(m_active && m_pos == 0));
        check("model_div_out", 16'(div_out), 16'(exp_div));
        check("model_cur_div", 16'(cur_div), 16'(m_ratio));
        check("model_cfg_err", 16'(cfg_err), 16'(m_err));
        check("model_cfg_ready", 16'(cfg_ready), 16'(!reset && model_ready()));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic capture(input int n, output logic [15:0] dv, output logic [15:0] tk);
        dv = '0;
        tk = '0;
        for (int i = 0; i < n; i++) begin
            dv[n-1-i] = div_out;
            tk[n-1-i] = tick;
            cyc(1);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tick && n < 64);
    endtask

    initial begin : stim
        logic [15:0] dv, tk;
        int          n;
        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 4'd0;

        cyc(1);
        check("rst_cfg_ready", 16'(cfg_ready), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_div_out", 16'(div_out), 16'h0);
        check("rst_tick", 16'(tick), 16'h0);
        check("rst_cur_div", 16'(cur_div), 16'h0);
        check("rst_cfg_err", 16'(cfg_err), 16'h0);

        // Release between edges; the first edge afterwards accepts a ratio.
        #2;
        reset     = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 4'd4;
        cyc(1);
        check("idle_load_cur_div", 16'(cur_div), 16'd4);
        check("idle_load_quiet", 16'(busy), 16'h0);
        cfg_valid = 1'b0;
        en        = 1'b1;
        cyc(1);

        capture(8, dv, tk);
        check("n4_div_pattern", dv, 16'b11001100);
        check("n4_tick_pattern", tk, 16'b10001000);

        // Mid-period request at ratio 4 becomes 5 at the next boundary.
        cfg_valid = 1'b1;
        cfg_div   = 4'd5;
        cyc(1);
        check("pend_ready_low", 16'(cfg_ready), 16'h0);
        cfg_valid = 1'b0;
        cyc(3);
        check("n5_cur_div", 16'(cur_div), 16'd5);
        capture(10, dv, tk);
`ifdef CLKDIV_ODD_DUTY_EN
        check("n5_div_pattern", dv, 16'b0110001100);
`else
        check("n5_div_pattern", dv, 16'b1110011100);
`endif
        check("n5_tick_pattern", tk, 16'b1000010000);

        // Request on the wrap edge itself applies immediately.
        cyc(4);
        cfg_valid = 1'b1;
        cfg_div   = 4'd6;
        cyc(1);
        check("wrap_xfer_cur_div", 16'(cur_div), 16'd6);
        check("wrap_xfer_tick", 16'(tick), 16'h1);
        check("wrap_xfer_ready", 16'(cfg_ready), 16'h1);
        cfg_valid = 1'b0;

        // N=6, request N=3 on the edge where cnt=2.
        cyc(2);
        cfg_valid = 1'b1;
        cfg_div   = 4'd3;
        cyc(1);
        check("n6_pend_ready", 16'(cfg_ready), 16'h0);
        check("n6_pend_cur_div", 16'(cur_div), 16'd6);
        cfg_valid = 1'b0;
        wait_tick(n);
        check("n6_period_rest", 16'(n), 16'd3);
        check("n3_cur_div", 16'(cur_div), 16'd3);
        wait_tick(n);
        check("n3_period", 16'(n), 16'd3);

        // Illegal ratio.
        cfg_valid = 1'b1;
        cfg_div   = 4'd1;
        cyc(1);
        check("err_pulse", 16'(cfg_err), 16'h1);
        check("err_cur_div", 16'(cur_div), 16'd3);
        cfg_valid = 1'b0;
        cyc(1);
        check("err_pulse_end", 16'(cfg_err), 16'h0);
        cyc(1);

        // Move to N=8, then drop en on the edge where cnt=1.
        cfg_valid = 1'b1;
        cfg_div   = 4'd8;
        cyc(1);
        cfg_valid = 1'b0;
        cyc(2);
        check("n8_cur_div", 16'(cur_div), 16'd8);
        cyc(1);
        en = 1'b0;
        n  = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (!busy) break;
            n++;
        end
        check("stop_cycles", 16'(n), 16'd6);
        check("stop_busy", 16'(busy), 16'h0);
        check("stop_div_out", 16'(div_out), 16'h0);
        check("stop_tick", 16'(tick), 16'h0);

        // Restart, stop briefly, resume before the wrap.
        en = 1'b1;
        cyc(1);
        en = 1'b0;
        cyc(1);
        check("stop_ready_low", 16'(cfg_ready), 16'h0);
        check("stop_busy_high", 16'(busy), 16'h1);
        en = 1'b1;
        wait_tick(n);
        check("resume_period", 16'(n), 16'd7);

        // Reset between edges while a ratio is pending.
        cfg_valid = 1'b1;
        cfg_div   = 4'd3;
        cyc(1);
        check("pre_rst_pend_ready", 16'(cfg_ready), 16'h0);
        cfg_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_div_out", 16'(div_out), 16'h0);
        check("async_rst_busy", 16'(busy), 16'h0);
        check("async_rst_tick", 16'(tick), 16'h0);
        check("async_rst_cur_div", 16'(cur_div), 16'h0);
        check("async_rst_ready", 16'(cfg_ready), 16'h0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        cyc(3);
        check("no_start_unloaded", 16'(busy), 16'h0);
        check("no_start_div_out", 16'(div_out), 16'h0);

        // Load and start on the same edge.
        cfg_valid = 1'b1;
        cfg_div   = 4'd2;
        cyc(1);
        cfg_valid = 1'b0;
        check("same_edge_tick", 16'(tick), 16'h1);
        check("same_edge_div_out", 16'(div_out), 16'h1);
        check("same_edge_cur_div", 16'(cur_div), 16'd2);
        cyc(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
